nibble_serial_adder: RTL and testbench

//  Multi-cycle wide adder built around the existing 4-bit structural ripple adder.

---
 rtl/nibble_serial_adder.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder that streams one nibble per cycle through an external 4-bit adder.
// Optional macro ADD_SUB_EN adds a 'sub' input selecting A-B instead of A+B+cin.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef ADD_SUB_EN
    input  logic                 sub,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = op_a;
`ifdef ADD_SUB_EN
                    // Subtraction is A + ~B + 1, so the seed carry replaces cin.
                    b_d      = sub ? ~op_b : op_b;
                    carry_d  = sub ? 1'b1 : cin;
`else
                    b_d      = op_b;
                    carry_d  = cin;
`endif
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = a_q[4*idx_q +: 4];
                add_b   = b_q[4*idx_q +: 4];
                add_cin = carry_q;
                result_d[4*idx_q +: 4] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            // NOTE: operand registers are reset too, so an aborted operation leaves nothing stale behind.
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values together.
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: models the external 4-bit adder and
// compares each wide result against plain W-bit arithmetic.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         cout;
`ifdef ADD_SUB_EN
    logic         sub_i = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external 4-bit ripple adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 5'(add_cin);

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ADD_SUB_EN
        .sub       (sub_i),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        n_vec++;
        if ({in_ready, out_valid, result, cout, add_a, add_b, add_cin} !==
            {1'b1, 1'b0, {W{1'b0}}, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL %s: got rdy=%b vld=%b res=%h cout=%b a=%h b=%h ci=%b, want rdy=1 vld=0 res=0 cout=0 a=0 b=0 ci=0",
                     name, in_ready, out_valid, result, cout, add_a, add_b, add_cin);
        end
    endtask

    task automatic check_idle_bus(input string name);
        n_vec++;
        if ({in_ready, out_valid, add_a, add_b, add_cin} !== {1'b1, 1'b0, 9'h0}) begin
            n_err++;
            $display("FAIL %s: got rdy=%b vld=%b a=%h b=%h ci=%b, want rdy=1 vld=0 adder inputs 0",
                     name, in_ready, out_valid, add_a, add_b, add_cin);
        end
    endtask

    // One full operation: accept, NIBBLES run cycles, 'hold' cycles of backpressure, handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input int hold, input string name);
        logic [W:0]   full, mask, lo, a_x, bb_x;
        logic [W-1:0] bb, exp_res;
        logic         c0, exp_cout, exp_ci;
        int           waited;

        bb = s ? ~b : b;
        c0 = s ? 1'b1 : c;
        if (s) begin
            exp_res  = a - b;
            exp_cout = (a >= b);
        end else begin
            full     = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            exp_res  = full[W-1:0];
            exp_cout = full[W];
        end

        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: in_ready=%b after %0d cycles, want 1", name, in_ready, waited);
        end

        op_a = a;
        op_b = b;
        cin  = c;
`ifdef ADD_SUB_EN
        sub_i = s;
`endif
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        cin  = 1'($urandom);
`ifdef ADD_SUB_EN
        sub_i = 1'($urandom);
`endif

        a_x  = {1'b0, a};
        bb_x = {1'b0, bb};
        for (int k = 0; k < NIBBLES; k++) begin
            mask   = ((W+1)'(1) << (4 * k)) - (W+1)'(1);
            lo     = (a_x & mask) + (bb_x & mask) + (W+1)'(c0);
            exp_ci = lo[4*k];
            n_vec++;
            if ({out_valid, in_ready, add_a, add_b, add_cin} !==
                {1'b0, 1'b0, a[4*k +: 4], bb[4*k +: 4], exp_ci}) begin
                n_err++;
                $display("FAIL %s run%0d: got vld=%b rdy=%b a=%h b=%h ci=%b, want vld=0 rdy=0 a=%h b=%h ci=%b",
                         name, k, out_valid, in_ready, add_a, add_b, add_cin,
                         a[4*k +: 4], bb[4*k +: 4], exp_ci);
            end
            step();
        end

        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s latency: out_valid=%b after %0d edges, want 1", name, out_valid, NIBBLES);
            waited = 0;
            while (out_valid !== 1'b1 && waited < 8) begin
                step();
                waited++;
            end
        end
        n_vec++;
        if ({result, cout} !== {exp_res, exp_cout}) begin
            n_err++;
            $display("FAIL %s result: got %h cout=%b, want %h cout=%b", name, result, cout, exp_res, exp_cout);
        end

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            op_a      = W'($urandom);
            op_b      = W'($urandom);
            step();
            n_vec++;
            if ({out_valid, in_ready, result, cout, add_a, add_b, add_cin} !==
                {1'b1, 1'b0, exp_res, exp_cout, 9'h0}) begin
                n_err++;
                $display("FAIL %s hold%0d: got vld=%b rdy=%b res=%h cout=%b a=%h b=%h ci=%b, want vld=1 rdy=0 res=%h cout=%b adder 0",
                         name, h, out_valid, in_ready, result, cout, add_a, add_b, add_cin, exp_res, exp_cout);
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_idle_bus({name, " release"});
        n_vec++;
        if ({result, cout} !== {exp_res, exp_cout}) begin
            n_err++;
            $display("FAIL %s kept: got %h cout=%b, want %h cout=%b", name, result, cout, exp_res, exp_cout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle_bus("post_reset_idle");
    endtask

    task automatic test_basic();
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "t1");
        n_vec++;
        if ({result, cout} !== {16'h5555, 1'b0}) begin
            n_err++;
            $display("FAIL t1_const: got %h cout=%b, want 5555 cout=0", result, cout);
        end
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, "t2_ripple");
        n_vec++;
        if ({result, cout} !== {16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL t2_ripple_const: got %h cout=%b, want 0000 cout=1", result, cout);
        end
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, "t2_cin");
        n_vec++;
        if ({result, cout} !== {16'h0001, 1'b0}) begin
            n_err++;
            $display("FAIL t2_cin_const: got %h cout=%b, want 0001 cout=0", result, cout);
        end
    endtask

    task automatic test_backpressure();
        do_op(16'hBEEF, 16'h1111, 1'b1, 1'b0, 10, "t3_backpressure");
    endtask

    task automatic test_abort_reset();
        op_a = 16'h1357;
        op_b = 16'h2468;
        cin  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_reset_values("t4_abort");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle_bus("t4_idle");
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "t4_next");
        n_vec++;
        if ({result, cout} !== {16'h0100, 1'b0}) begin
            n_err++;
            $display("FAIL t4_next_const: got %h cout=%b, want 0100 cout=0", result, cout);
        end
    endtask

`ifdef ADD_SUB_EN
    task automatic test_sub();
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "t5_borrow");
        n_vec++;
        if ({result, cout} !== {16'hFFFE, 1'b0}) begin
            n_err++;
            $display("FAIL t5_borrow_const: got %h cout=%b, want fffe cout=0", result, cout);
        end
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 2, "t5_noborrow");
        n_vec++;
        if ({result, cout} !== {16'h0002, 1'b1}) begin
            n_err++;
            $display("FAIL t5_noborrow_const: got %h cout=%b, want 0002 cout=1", result, cout);
        end
    endtask
`endif

    task automatic test_random();
        logic s;
        int   gap;
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                check_idle_bus("t6_gap");
            end
`ifdef ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), 1'($urandom), s, $urandom_range(0, 3), "t6_random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort_reset();
`ifdef ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
